prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_asm.sv | 45 ++++
 rtl/prog_loader.sv | 150 +++++++++++++++
 tb/tb_prog_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_CHK  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/prog_loader_asm.sv
// Packs little-endian bytes into 32-bit words; emits a registered one-cycle word strobe.
module prog_loader_asm
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_valid,
  output logic              byte_last_c,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid
);

  localparam int unsigned CNT_W  = $clog2(WORD_BYTES);
  localparam int unsigned PART_W = (WORD_BYTES - 1) * BYTE_W;

  logic [CNT_W-1:0]  cnt_q;
  logic [PART_W-1:0] part_q;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;

  assign byte_last_c = (cnt_q == CNT_W'(WORD_BYTES - 1));
  assign word_data   = word_q;
  assign word_valid  = valid_q;

  // Earlier bytes shift down so byte0 ends up in the lowest lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      part_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= byte_valid && byte_last_c;
      if (byte_valid) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        part_q <= {byte_data, part_q[PART_W-1:BYTE_W]};
        if (byte_last_c) begin
          word_q <= {byte_data, part_q};
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte image into instruction memory,
// then releases the core from reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W       = ADDR_W + 1;
  localparam int unsigned HDR_CNT_W   = $clog2(HDR_BYTES);
  localparam int unsigned HDR_SHIFT_W = (HDR_BYTES - 1) * BYTE_W;
  localparam logic [WORD_W:0] CAPACITY = (WORD_W + 1)'(1) << ADDR_W;

  state_e state_q, state_d;

  logic [HDR_CNT_W-1:0]   hdr_cnt_q;
  logic [HDR_SHIFT_W-1:0] hdr_q;
  logic [CNT_W-1:0]       n_q;
  logic [CNT_W-1:0]       word_cnt_q;
  logic [BYTE_W-1:0]      sum_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   in_ready_q;
  logic                   core_rst_n_q;
  logic                   done_q;
  logic                   err_q;

  logic                   accept_c;
  logic                   hdr_byte_c;
  logic                   hdr_last_c;
  logic                   load_byte_c;
  logic                   byte_last_c;
  logic                   word_last_c;
  logic                   n_zero_c;
  logic                   n_over_c;
  logic [WORD_W-1:0]      n_word_c;
  logic [WORD_W-1:0]      asm_word;
  logic                   asm_valid;

  assign accept_c    = in_valid && in_ready_q;
  assign hdr_byte_c  = accept_c && (state_q == ST_HDR);
  assign load_byte_c = accept_c && (state_q == ST_LOAD);
  assign hdr_last_c  = (hdr_cnt_q == HDR_CNT_W'(HDR_BYTES - 1));
  assign n_word_c    = {in_data, hdr_q};
  assign n_zero_c    = (n_word_c == '0);
  assign n_over_c    = ({1'b0, n_word_c} > CAPACITY);
  assign word_last_c = ((word_cnt_q + CNT_W'(1)) == n_q);

  prog_loader_asm u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_data   (in_data),
    .byte_valid  (load_byte_c),
    .byte_last_c (byte_last_c),
    .word_data   (asm_word),
    .word_valid  (asm_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE and ERR hold until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (hdr_byte_c && hdr_last_c) begin
          if (n_zero_c)      state_d = ST_CHK;
          else if (n_over_c) state_d = ST_ERR;
          else               state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_byte_c && byte_last_c && word_last_c) state_d = ST_CHK;
      end
      ST_CHK: begin
        if (accept_c) state_d = (in_data == sum_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_HDR;
    endcase
  end

  // Status outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      in_ready_q   <= (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_CHK);
      core_rst_n_q <= (state_d == ST_DONE);
      done_q       <= (state_d == ST_DONE);
      err_q        <= (state_d == ST_ERR);
    end
  end

  // Header capture, word/byte bookkeeping and write address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt_q  <= '0;
      hdr_q      <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      sum_q      <= '0;
      addr_q     <= ADDR_W'(BASE_ADDR);
    end else begin
      if (hdr_byte_c) begin
        hdr_cnt_q <= hdr_cnt_q + HDR_CNT_W'(1);
        hdr_q     <= {in_data, hdr_q[HDR_SHIFT_W-1:BYTE_W]};
        if (hdr_last_c) n_q <= CNT_W'(n_word_c);
      end
      if (load_byte_c) begin
        sum_q <= sum_q + in_data;
        if (byte_last_c) word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
      // Advance after each write so word k lands at BASE_ADDR + k.
      if (asm_valid) addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = asm_valid;
  assign imem_addr  = addr_q;
  assign imem_wdata = asm_word;
  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised self-checking bench for prog_loader against a stream-level reference model.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n12, rst_n4;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        rdy12, we12, crst12, done12, err12;
  logic [11:0] addr12;
  logic [31:0] wdata12;
  logic        rdy4, we4, crst4, done4, err4;
  logic [3:0]  addr4;
  logic [31:0] wdata4;

  logic        m_ready, m_we, m_crst, m_done, m_err;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  bit          sel4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         got_q[$];
  logic [7:0]  stream[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_cyc[$];
  bit          exp_done, exp_err;
  int          img_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n12), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy12),
    .imem_we(we12), .imem_addr(addr12), .imem_wdata(wdata12), .core_rst_n(crst12),
    .done(done12), .err(err12));

  prog_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .rst_n(rst_n4), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
    .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4), .core_rst_n(crst4),
    .done(done4), .err(err4));

  always_comb begin
    m_ready = sel4 ? rdy4  : rdy12;
    m_we    = sel4 ? we4   : we12;
    m_addr  = sel4 ? {8'h00, addr4} : addr12;
    m_wdata = sel4 ? wdata4 : wdata12;
    m_crst  = sel4 ? crst4 : crst12;
    m_done  = sel4 ? done4 : done12;
    m_err   = sel4 ? err4  : err12;
  end

  always @(negedge clk) if (m_we) got_q.push_back('{int'(m_addr), m_wdata, cyc});

  // Reference model: image bytes, expected writes and final outcome.
  function automatic void build_image(input int n, input logic [31:0] words[$],
                                      input bit good_ck, input logic [7:0] ck_val, input int aw);
    logic [7:0] sum;
    logic [7:0] ck;
    int cap;
    cap = 1 << aw;
    stream.delete(); exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    img_n = n;
    for (int i = 0; i < 4; i++) stream.push_back(8'((n >> (8 * i)) & 255));
    sum = 8'h00;
    for (int k = 0; k < words.size(); k++) begin
      for (int i = 0; i < 4; i++) begin
        stream.push_back(words[k][8*i +: 8]);
        sum = sum + words[k][8*i +: 8];
      end
      if (n <= cap) begin
        exp_addr.push_back(k % cap);
        exp_data.push_back(words[k]);
      end
    end
    ck = good_ck ? sum : ck_val;
    stream.push_back(ck);
    exp_done = (n <= cap) && (ck == sum);
    exp_err  = !exp_done;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input int budget,
                           output bit ok, output int edge_n);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    ok = 1'b0;
    edge_n = -1;
    for (int t = 0; t < budget && !ok; t++) begin
      if (m_ready) begin
        ok = 1'b1;
        edge_n = cyc + 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_image(input int maxgap);
    bit ok;
    int e;
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], $urandom_range(0, maxgap), 50, ok, e);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL accept_timeout byte %0d not accepted within budget", i);
        return;
      end
      if (i >= 4 && i < 4 + 4 * img_n && ((i - 4) % 4) == 3) exp_cyc.push_back(e);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input bit four);
    @(negedge clk);
    sel4 = four;
    in_valid = 1'b0;
    rst_n12 = 1'b0;
    rst_n4 = 1'b0;
    repeat (2) @(negedge clk);
    if (four) rst_n4 = 1'b1; else rst_n12 = 1'b1;
    got_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    sel4 = 1'b0;
    rst_n12 = 1'b0;
    @(negedge clk);
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", m_ready); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", m_we); end
    checks++; if (m_addr !== 12'd0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", m_addr); end
    checks++; if (m_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", m_wdata); end
    checks++; if ({m_crst, m_done, m_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {m_crst, m_done, m_err}); end
    rst_n12 = 1'b1;
    got_q.delete();
    @(negedge clk);
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", m_ready); end
    checks++; if ({m_crst, m_done, m_err} !== 3'b000) begin errors++; $display("FAIL post_rst_flags got=%b exp=000", {m_crst, m_done, m_err}); end
  endtask

  task automatic test_image(input string name, input bit four, input int n, input logic [31:0] words[$],
                            input bit good_ck, input logic [7:0] ck_val, input int maxgap);
    do_reset(four);
    build_image(n, words, good_ck, ck_val, four ? 4 : 12);
    send_image(maxgap);
    checks++;
    if (got_q.size() != exp_data.size()) begin
      errors++; $display("FAIL %s write_count got=%0d exp=%0d", name, got_q.size(), exp_data.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_data.size(); k++) begin
      checks++;
      if (got_q[k].addr != exp_addr[k] || got_q[k].data !== exp_data[k]) begin
        errors++; $display("FAIL %s write%0d got=%0d:%h exp=%0d:%h", name, k, got_q[k].addr, got_q[k].data, exp_addr[k], exp_data[k]);
      end
      if (k < exp_cyc.size()) begin
        checks++;
        if (got_q[k].cyc != exp_cyc[k]) begin
          errors++; $display("FAIL %s write%0d_timing got_cycle=%0d exp_cycle=%0d", name, k, got_q[k].cyc, exp_cyc[k]);
        end
      end
    end
    checks++; if (m_done !== exp_done) begin errors++; $display("FAIL %s done got=%b exp=%b", name, m_done, exp_done); end
    checks++; if (m_err !== exp_err) begin errors++; $display("FAIL %s err got=%b exp=%b", name, m_err, exp_err); end
    checks++; if (m_crst !== exp_done) begin errors++; $display("FAIL %s core_rst_n got=%b exp=%b", name, m_crst, exp_done); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready got=%b exp=0", name, m_ready); end
  endtask

  task automatic test_terminal();
    bit ok;
    int e;
    int nw;
    nw = got_q.size();
    send_byte(8'h5A, 0, 6, ok, e);
    repeat (2) @(negedge clk);
    checks++; if (ok) begin errors++; $display("FAIL terminal_accept got=1 exp=0"); end
    checks++; if (got_q.size() != nw) begin errors++; $display("FAIL terminal_writes got=%0d exp=%0d", got_q.size(), nw); end
    checks++; if (m_done !== exp_done || m_err !== exp_err) begin errors++; $display("FAIL terminal_flags got=%b%b exp=%b%b", m_done, m_err, exp_done, exp_err); end
  endtask

  task automatic test_oversize();
    logic [31:0] none[$];
    bit ok;
    int e;
    do_reset(1'b1);
    build_image(17, none, 1'b1, 8'h00, 4);
    for (int i = 0; i < 4; i++) begin
      send_byte(stream[i], 0, 50, ok, e);
      if (!ok) begin checks++; errors++; $display("FAIL oversize_hdr_timeout byte %0d", i); end
    end
    checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL oversize_err got=%b exp=1", m_err); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL oversize_in_ready got=%b exp=0", m_ready); end
    checks++; if (m_done !== 1'b0 || m_crst !== 1'b0) begin errors++; $display("FAIL oversize_done_crst got=%b%b exp=00", m_done, m_crst); end
    send_byte(8'h11, 0, 6, ok, e);
    checks++; if (ok) begin errors++; $display("FAIL oversize_payload_accept got=1 exp=0"); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL oversize_writes got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_mid_reset(input logic [31:0] words[$]);
    bit ok;
    int e;
    do_reset(1'b0);
    build_image(2, words, 1'b1, 8'h00, 12);
    for (int i = 0; i < 10; i++) begin
      send_byte(stream[i], 0, 50, ok, e);
      if (!ok) begin checks++; errors++; $display("FAIL midrst_timeout byte %0d", i); end
    end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL midrst_partial_writes got=%0d exp=1", got_q.size()); end
    #2 rst_n12 = 1'b0;
    #1;
    checks++; if ({m_ready, m_we, m_crst, m_done, m_err} !== 5'b0 || m_addr !== 12'd0) begin
      errors++; $display("FAIL midrst_async got=%b addr=%0h exp=00000 addr=0", {m_ready, m_we, m_crst, m_done, m_err}, m_addr);
    end
    @(negedge clk);
    rst_n12 = 1'b1;
    got_q.delete();
    build_image(2, words, 1'b1, 8'h00, 12);
    send_image(0);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL midrst_writes got=%0d exp=2", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 2; k++) begin
      checks++;
      if (got_q[k].addr != exp_addr[k] || got_q[k].data !== exp_data[k]) begin
        errors++; $display("FAIL midrst_write%0d got=%0d:%h exp=%0d:%h", k, got_q[k].addr, got_q[k].data, exp_addr[k], exp_data[k]);
      end
    end
    checks++; if (m_done !== 1'b1 || m_crst !== 1'b1) begin errors++; $display("FAIL midrst_done got=%b%b exp=11", m_done, m_crst); end
  endtask

  task automatic test_random_images();
    logic [31:0] w[$];
    int n;
    bit good;
    for (int it = 0; it < 5; it++) begin
      w.delete();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) w.push_back($urandom());
      good = 1'($urandom_range(0, 1));
      test_image("random", 1'b0, n, w, good, 8'($urandom()), 3);
      test_terminal();
    end
  endtask

  initial begin
    logic [31:0] img[$];
    logic [31:0] none[$];
    logic [31:0] full16[$];
    in_valid = 1'b0;
    in_data = 8'h00;
    rst_n12 = 1'b0;
    rst_n4 = 1'b0;
    sel4 = 1'b0;
    img.push_back(32'h00500093);
    img.push_back(32'h00100113);
    for (int k = 0; k < 16; k++) full16.push_back($urandom());
    repeat (2) @(negedge clk);

    test_reset();
    test_image("good", 1'b0, 2, img, 1'b1, 8'h00, 0);
    test_terminal();
    test_image("bad_checksum", 1'b0, 2, img, 1'b0, 8'h00, 0);
    test_terminal();
    test_image("empty", 1'b0, 0, none, 1'b0, 8'h00, 0);
    test_oversize();
    test_image("full_capacity", 1'b1, 16, full16, 1'b1, 8'h00, 1);
    test_image("gaps", 1'b0, 2, img, 1'b1, 8'h00, 5);
    test_mid_reset(img);
    test_random_images();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule
